wam_mole: RTL
=============

# wam_mole

Mole spawner and lifetime manager for the Whac-A-Mole game. It consumes the difficulty outputs `age` (mole lifetime) and `rto` (spawn ratio) from the hardness controller. It spawns moles into holes pseudo-randomly, expires and scores them against player hit pulses, and returns the `cout0` pulse that makes the game harder. It sits between the hardness controller, the debounced button front-end and the LED/7-segment display drivers.

## Interface
Parameters:
- `NUM_HOLES`, default 8: number of holes. Must be a power of two, 2..16.
- `MAX_MISS`, default 9: miss count at which the game ends, 1..15.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`, input, 1: system clock.
- `clr`, input, 1: reset, asynchronous, active-high.
- `tick`, input, 1: one-`clk` game-time pulse, about 4 Hz.
- `age`, input, 4: mole lifetime in ticks. 0 is treated as 1.
- `rto`, input, 8: spawn threshold. Spawn probability per tick is rto/256.
- `hit`, input, NUM_HOLES: one-`clk` whack pulses, one bit per hole.
- `mole`, output, NUM_HOLES: bit i set means a mole is up in hole i.
- `score_lo`, output, 4: score units, BCD.
- `score_hi`, output, 4: score tens, BCD.
- `miss`, output, 4: miss count.
- `cout0`, output, 1: one-`clk` pulse when `score_lo` wraps 9→0.
- `game_over`, output, 1: high once `miss` reaches MAX_MISS.

## Operation
- **Reset values.** On `clr`, all outputs reset to 0. The LFSR resets to LFSR_SEED, and all per-hole life counters reset to 0.
- **LFSR.** 16-bit Fibonacci LFSR, taps 16,14,13,11. It steps every `clk`, independent of `tick`.
- **Registers.** Each hole has a 4-bit life counter `life[i]`. `mole[i]` is registered and equals `life[i] != 0`.
- **Decision basis.** Every decision in a cycle uses the pre-edge state, and all updates land on the same edge.
- **Hit.**
  - `hit[i]` with `mole[i]`=1 clears `life[i]` and increments the score.
  - Several simultaneous valid hits each score, up to NUM_HOLES per cycle. The score is added as a BCD sum with the carry chained.
- **Tick expiry.**
  - Each `tick` decrements every nonzero `life[i]` that was not hit this cycle.
  - A decrement from 1 to 0 increments `miss`. Multiple expiries in one tick each count.
  - `miss` saturates at 15.
- **Tick spawn.**
  - Spawn when `lfsr[7:0] < rto`.
  - Target hole = `lfsr[8 +: log2(NUM_HOLES)]`.
  - If the target hole was occupied pre-edge, nothing spawns and nothing is retried.
  - A spawned mole loads `life` = max(`age`,1).
  - A spawn into a hole that is also being hit on an empty bit is allowed; that hit has no effect.
- **Simultaneous events.** Hit and expiry on the same hole in the same cycle: the hit wins, it scores, and there is no miss.
- **Score.**
  - Two-digit BCD counter, 00..99.
  - It wraps 99→00, and `cout0` pulses on that wrap too.
  - `cout0` is asserted on every units 9→0 transition, including when a multi-hit carries past 9.
- **Game over.**
  - `game_over` is set when `miss` ≥ MAX_MISS and is sticky until `clr`.
  - While `game_over` is high: no spawns, hits are ignored, and `mole` clears on the next edge.
- **Invariant.** No hole ever holds a mole with `life` = 0.

## Timing
- All outputs are registered: 1-cycle latency from `hit`/`tick` to `mole`/score/`miss`.
- `cout0` is registered and glitch-free, exactly one `clk` wide, because the hardness controller is edge-triggered on it. Two consecutive wraps produce two separate pulses.
- `age`/`rto` are sampled only on the `tick` cycle. A change mid-life does not alter moles already up.
- `clr` mid-game clears everything asynchronously. The first spawn is possible on the first `tick` after deassertion.
- Between ticks, `life` values are static. Lifetime is `age` ticks ±1 `tick` of phase.

## Configuration
- `WAM_MISS_PENALTY_EN`:
  - **Defined:** a hit on an empty hole (pre-edge `mole[i]`=0, `game_over`=0) increments `miss`, saturating, once per cycle regardless of how many empty holes are hit.
  - **Undefined:** empty-hole hits are ignored.

## Structure
- `wam_pkg` holds:
  - the LFSR tap constant and width;
  - the `bcd_t` 4-bit typedef;
  - the BCD-increment function;
  - the `MISS_W`=4 and `LIFE_W`=4 constants.
- Sub-module `wam_lfsr`: the seeded 16-bit LFSR with `clk`/`clr`, exposing the full state.
- Per-hole life logic is a generate loop; no further sub-modules.

## Test plan
- **Spawn and expiry.** `clr`, then `rto`=255, `age`=3, 4 ticks, no hits → exactly one `mole` bit set after tick 1; it expires after tick 4 with `miss`=1 if no respawn hit that hole, and `life` never exceeds 3.
- **Cleared by hit.** Mole up in hole 2, pulse `hit[2]` → `mole[2]`=0 and `score_lo`=1 next cycle; `hit[5]` on an empty hole → no change (macro undefined) or `miss`+1 (macro defined).
- **Score wrap.** Preload score 09 via 9 hits, one more valid hit → score 10, `cout0` high for exactly one `clk`. From 99, one hit → 00 and `cout0` pulses.
- **Hit beats expiry.** `life`=1 in hole 0 with `tick` and `hit[0]` in the same cycle → score+1, `miss` unchanged.
- **Game over.** `MAX_MISS`=2, `rto`=255, `age`=1, no hits → `game_over` after the second miss, `mole`=0, and later ticks and hits produce no change until `clr`.
- **Reset mid-game.** Assert `clr` mid-game with moles up → all outputs 0 immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared constants, types and the BCD digit helper for the Whac-A-Mole mole manager.
package wam_pkg;

   localparam int               LFSR_W    = 16;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10 of the state
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam int               MISS_W    = 4;
   localparam int               LIFE_W    = 4;

   typedef logic [3:0] bcd_t;

   function automatic bcd_t bcd_inc(input bcd_t d);
      bcd_t r;
      if (d >= 4'd9) begin
         r = 4'd0;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running seeded 16-bit Fibonacci LFSR; steps on every clk edge.
module wam_lfsr
   import wam_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              clr,
   output logic [LFSR_W-1:0] o_state
);

   logic [LFSR_W-1:0] r_state;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= SEED;
      end else begin
         r_state <= {r_state[LFSR_W-2:0], ^(r_state & LFSR_TAPS)};
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/wam_mole.sv
// Mole spawner/lifetime manager: spawns on tick from the LFSR, ages and expires moles, scores hits in BCD.
// Build option WAM_MISS_PENALTY_EN: a hit on an empty hole also costs one miss per cycle.
module wam_mole
   import wam_pkg::*;
#(
   parameter int          NUM_HOLES = 8,
   parameter int          MAX_MISS  = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 tick,
   input  logic [3:0]           age,
   input  logic [7:0]           rto,
   input  logic [NUM_HOLES-1:0] hit,
   output logic [NUM_HOLES-1:0] mole,
   output logic [3:0]           score_lo,
   output logic [3:0]           score_hi,
   output logic [3:0]           miss,
   output logic                 cout0,
   output logic                 game_over
);

   localparam int HOLE_W = $clog2(NUM_HOLES);

   logic [LFSR_W-1:0]    w_lfsr;
   logic                 w_unused;
   logic                 w_spawn_en;
   logic [HOLE_W-1:0]    w_target;
   logic [LIFE_W-1:0]    w_age_eff;
   logic [NUM_HOLES-1:0] w_hit_ok;
   logic [NUM_HOLES-1:0] w_expire;
   logic [NUM_HOLES-1:0] w_mole_next;
   logic                 w_penalty;
   bcd_t                 w_lo;
   bcd_t                 w_hi;
   logic                 w_wrap;
   logic [5:0]           w_miss_sum;
   logic [MISS_W-1:0]    w_miss_next;

   wam_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .clr     (clr),
      .o_state (w_lfsr)
   );

   assign w_unused   = ^w_lfsr;
   assign w_spawn_en = tick && !game_over && (w_lfsr[7:0] < rto);
   assign w_target   = w_lfsr[8 +: HOLE_W];
   assign w_age_eff  = (age == 4'd0) ? LIFE_W'(1) : age;
   // mole mirrors life != 0, so it is the pre-edge occupancy used for hit validation
   assign w_hit_ok   = hit & mole & {NUM_HOLES{!game_over}};

`ifdef WAM_MISS_PENALTY_EN
   assign w_penalty = !game_over && ((hit & ~mole) != {NUM_HOLES{1'b0}});
`else
   assign w_penalty = 1'b0;
`endif

   for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
      logic [LIFE_W-1:0] r_life;
      logic [LIFE_W-1:0] w_life_next;
      logic              w_spawn_here;

      assign w_spawn_here = w_spawn_en && (w_target == HOLE_W'(i)) && (r_life == LIFE_W'(0));
      // A hit takes priority over expiry, so the last tick of life can still score
      assign w_expire[i]  = tick && !game_over && !w_hit_ok[i] && (r_life == LIFE_W'(1));

      always_comb begin
         if (game_over) begin
            w_life_next = LIFE_W'(0);
         end else if (w_hit_ok[i]) begin
            w_life_next = LIFE_W'(0);
         end else if (tick && (r_life != LIFE_W'(0))) begin
            w_life_next = r_life - LIFE_W'(1);
         end else if (w_spawn_here) begin
            w_life_next = w_age_eff;
         end else begin
            w_life_next = r_life;
         end
      end

      always_ff @(posedge clk or posedge clr) begin
         if (clr) begin
            r_life <= LIFE_W'(0);
         end else begin
            r_life <= w_life_next;
         end
      end

      assign w_mole_next[i] = (w_life_next != LIFE_W'(0));
   end

   // Each valid hit advances the units digit once; a 9->0 step carries into tens and flags a wrap
   always_comb begin
      w_lo   = score_lo;
      w_hi   = score_hi;
      w_wrap = 1'b0;
      for (int k = 0; k < NUM_HOLES; k++) begin
         if (w_hit_ok[k]) begin
            if (w_lo == 4'd9) begin
               w_wrap = 1'b1;
               w_hi   = bcd_inc(w_hi);
            end else begin
               w_hi   = w_hi;
            end
            w_lo = bcd_inc(w_lo);
         end else begin
            w_lo = w_lo;
         end
      end
   end

   always_comb begin
      w_miss_sum = {2'b00, miss} + {5'd0, w_penalty};
      for (int k = 0; k < NUM_HOLES; k++) begin
         if (w_expire[k]) begin
            w_miss_sum = w_miss_sum + 6'd1;
         end else begin
            w_miss_sum = w_miss_sum;
         end
      end
      if (w_miss_sum > 6'd15) begin
         w_miss_next = 4'd15;
      end else begin
         w_miss_next = w_miss_sum[3:0];
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mole      <= {NUM_HOLES{1'b0}};
         score_lo  <= 4'd0;
         score_hi  <= 4'd0;
         miss      <= 4'd0;
         cout0     <= 1'b0;
         game_over <= 1'b0;
      end else begin
         mole      <= w_mole_next;
         score_lo  <= w_lo;
         score_hi  <= w_hi;
         miss      <= w_miss_next;
         cout0     <= w_wrap;
         game_over <= game_over | (w_miss_next >= MISS_W'(MAX_MISS));
      end
   end

endmodule
